// File: rtl/phy_rx_lanes.sv
// PHY receive path: registers the serial stream, aligns on COM_SYM and deserialises bytes round-robin over LANES lanes.
// Optional loss-of-sync detection is enabled by defining PHY_RX_LOS_EN.
module phy_rx_lanes #(
    parameter int                DATA_W    = 8,
    parameter int                LANES     = 4,
    parameter logic [DATA_W-1:0] COM_SYM   = 8'hBC,
    parameter int                SYNC_CNT  = 4,
    parameter int                LOS_LIMIT = 32
) (
    input  logic                    clk_32f,
    input  logic                    rst,
    input  logic                    serial_in,
    output logic [LANES*DATA_W-1:0] data_out,
    output logic [LANES-1:0]        valid_out,
    output logic                    active,
    output logic                    idle_out
);

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW = $clog2(SYNC_CNT + 1);

    typedef enum logic [1:0] {HUNT = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} state_t;

    state_t                  state_r, state_nxt_s;
    logic                    sin_q_r;
    logic [DATA_W-1:0]       shift_r;
    logic [BW-1:0]           bit_cnt_r, bit_cnt_nxt_s;
    logic [CW-1:0]           com_cnt_r, com_cnt_nxt_s;
    logic [PW-1:0]           ptr_r, ptr_nxt_s;
    logic [LANES-1:0]        fill_r, fill_nxt_s;
    logic [LANES*DATA_W-1:0] lane_r, lane_nxt_s;
    logic [LANES*DATA_W-1:0] data_out_r, data_nxt_s;
    logic [LANES-1:0]        valid_r, valid_nxt_s;
    logic                    active_r, active_nxt_s;
    logic                    idle_r, idle_nxt_s;
    logic                    byte_end_s, is_com_s, los_hit_s;

    assign byte_end_s = (bit_cnt_r == BW'(DATA_W - 1));
    assign is_com_s   = (shift_r == COM_SYM);

`ifdef PHY_RX_LOS_EN
    localparam int LW = $clog2(LOS_LIMIT + 1);
    logic [LW-1:0] los_cnt_r, los_nxt_s;

    assign los_hit_s = (state_r == LOCKED) && byte_end_s && !is_com_s &&
                       (los_cnt_r == LW'(LOS_LIMIT - 1));

    // Consecutive non-COM byte counter while locked.
    always_comb begin
        los_nxt_s = los_cnt_r;
        if (state_r != LOCKED || los_hit_s) begin
            los_nxt_s = {LW{1'b0}};
        end else if (byte_end_s) begin
            los_nxt_s = is_com_s ? {LW{1'b0}} : los_cnt_r + LW'(1);
        end else begin
            los_nxt_s = los_cnt_r;
        end
    end

    // Loss-of-sync counter register.
    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            los_cnt_r <= {LW{1'b0}};
        end else begin
            los_cnt_r <= los_nxt_s;
        end
    end
`else
    assign los_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            state_r <= HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: HUNT scans every bit, LOCKING/LOCKED act only on byte boundaries.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            HUNT: begin
                if (is_com_s) begin
                    state_nxt_s = (SYNC_CNT == 1) ? LOCKED : LOCKING;
                end else begin
                    state_nxt_s = HUNT;
                end
            end
            LOCKING: begin
                if (byte_end_s && is_com_s) begin
                    state_nxt_s = (com_cnt_r == CW'(SYNC_CNT - 1)) ? LOCKED : LOCKING;
                end else if (byte_end_s) begin
                    state_nxt_s = HUNT;
                end else begin
                    state_nxt_s = LOCKING;
                end
            end
            LOCKED: begin
                if (los_hit_s) begin
                    state_nxt_s = HUNT;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: state_nxt_s = HUNT;
        endcase
    end

    // Output/datapath next values: lane fill, group emit and partial flush.
    always_comb begin
        bit_cnt_nxt_s = byte_end_s ? {BW{1'b0}} : bit_cnt_r + BW'(1);
        com_cnt_nxt_s = com_cnt_r;
        ptr_nxt_s     = ptr_r;
        fill_nxt_s    = fill_r;
        lane_nxt_s    = lane_r;
        data_nxt_s    = data_out_r;
        valid_nxt_s   = {LANES{1'b0}};
        idle_nxt_s    = idle_r;
        case (state_r)
            HUNT: begin
                if (is_com_s) begin
                    bit_cnt_nxt_s = {BW{1'b0}};
                    com_cnt_nxt_s = CW'(1);
                end else begin
                    com_cnt_nxt_s = {CW{1'b0}};
                end
            end
            LOCKING: begin
                if (byte_end_s) begin
                    com_cnt_nxt_s = is_com_s ? com_cnt_r + CW'(1) : {CW{1'b0}};
                end else begin
                    com_cnt_nxt_s = com_cnt_r;
                end
            end
            LOCKED: begin
                if (byte_end_s && is_com_s) begin
                    idle_nxt_s = 1'b1;
                    if (ptr_r != {PW{1'b0}}) begin
                        for (int i = 0; i < LANES; i++) begin
                            if (fill_r[i]) begin
                                data_nxt_s[i*DATA_W +: DATA_W] = lane_r[i*DATA_W +: DATA_W];
                            end else begin
                                data_nxt_s[i*DATA_W +: DATA_W] = data_out_r[i*DATA_W +: DATA_W];
                            end
                        end
                        valid_nxt_s = fill_r;
                        ptr_nxt_s   = {PW{1'b0}};
                        fill_nxt_s  = {LANES{1'b0}};
                    end else begin
                        valid_nxt_s = {LANES{1'b0}};
                    end
                end else if (byte_end_s && !los_hit_s) begin
                    idle_nxt_s = 1'b0;
                    lane_nxt_s[int'(ptr_r)*DATA_W +: DATA_W] = shift_r;
                    fill_nxt_s[ptr_r] = 1'b1;
                    if (ptr_r == PW'(LANES - 1)) begin
                        data_nxt_s  = lane_nxt_s;
                        valid_nxt_s = {LANES{1'b1}};
                        ptr_nxt_s   = {PW{1'b0}};
                        fill_nxt_s  = {LANES{1'b0}};
                    end else begin
                        ptr_nxt_s = ptr_r + PW'(1);
                    end
                end else begin
                    valid_nxt_s = {LANES{1'b0}};
                end
            end
            default: com_cnt_nxt_s = {CW{1'b0}};
        endcase
        // Leaving or outside LOCKED always drops the partial group.
        if (state_nxt_s != LOCKED) begin
            idle_nxt_s = 1'b1;
            ptr_nxt_s  = {PW{1'b0}};
            fill_nxt_s = {LANES{1'b0}};
        end else begin
            idle_nxt_s = idle_nxt_s;
        end
        active_nxt_s = (state_nxt_s == LOCKED);
    end

    // Datapath and output registers.
    always_ff @(posedge clk_32f or posedge rst) begin
        if (rst) begin
            sin_q_r    <= 1'b0;
            shift_r    <= {DATA_W{1'b0}};
            bit_cnt_r  <= {BW{1'b0}};
            com_cnt_r  <= {CW{1'b0}};
            ptr_r      <= {PW{1'b0}};
            fill_r     <= {LANES{1'b0}};
            lane_r     <= {(LANES*DATA_W){1'b0}};
            data_out_r <= {(LANES*DATA_W){1'b0}};
            valid_r    <= {LANES{1'b0}};
            active_r   <= 1'b0;
            idle_r     <= 1'b1;
        end else begin
            sin_q_r    <= serial_in;
            shift_r    <= {shift_r[DATA_W-2:0], sin_q_r};
            bit_cnt_r  <= bit_cnt_nxt_s;
            com_cnt_r  <= com_cnt_nxt_s;
            ptr_r      <= ptr_nxt_s;
            fill_r     <= fill_nxt_s;
            lane_r     <= lane_nxt_s;
            data_out_r <= data_nxt_s;
            valid_r    <= valid_nxt_s;
            active_r   <= active_nxt_s;
            idle_r     <= idle_nxt_s;
        end
    end

    assign data_out  = data_out_r;
    assign valid_out = valid_r;
    assign active    = active_r;
    assign idle_out  = idle_r;

endmodule

// File: tb/tb_phy_rx_lanes.sv
// Self-checking bench for phy_rx_lanes: scoreboard of expected lane strobes plus per-scenario checks.
module tb_phy_rx_lanes;

    localparam logic [7:0] COM = 8'hBC;

    logic        clk_32f = 1'b0;
    logic        rst;
    logic        serial_in;
    logic [31:0] data_out;
    logic [3:0]  valid_out;
    logic        active;
    logic        idle_out;

    phy_rx_lanes #(
        .DATA_W(8), .LANES(4), .COM_SYM(8'hBC), .SYNC_CNT(4), .LOS_LIMIT(32)
    ) dut (
        .clk_32f(clk_32f), .rst(rst), .serial_in(serial_in),
        .data_out(data_out), .valid_out(valid_out), .active(active), .idle_out(idle_out)
    );

    always #5 clk_32f = ~clk_32f;

    typedef struct packed {
        logic [3:0]  v;
        logic [31:0] d;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_strobes = 0;
    logic       m_locked;
    int         m_ptr;
    int         m_los;
    logic [7:0] m_lane[4];
    logic [31:0] m_data;

    task automatic model_reset();
        m_locked = 1'b0;
        m_ptr    = 0;
        m_los    = 0;
        m_data   = 32'h0;
        sb_q.delete();
    endtask

    // Reference behaviour of one received byte; pushes any expected strobe.
    task automatic model_byte(input logic [7:0] b);
        logic [3:0] mk;
        if (!m_locked) return;
        if (b == COM) begin
            m_los = 0;
            if (m_ptr > 0) begin
                mk = 4'h0;
                for (int i = 0; i < m_ptr; i++) begin
                    m_data[i*8 +: 8] = m_lane[i];
                    mk[i] = 1'b1;
                end
                sb_q.push_back('{v: mk, d: m_data});
                m_ptr = 0;
            end
        end else begin
            m_los++;
`ifdef PHY_RX_LOS_EN
            if (m_los == 32) begin
                m_locked = 1'b0;
                m_ptr    = 0;
                m_los    = 0;
                return;
            end
`endif
            m_lane[m_ptr] = b;
            m_ptr++;
            if (m_ptr == 4) begin
                for (int i = 0; i < 4; i++) m_data[i*8 +: 8] = m_lane[i];
                sb_q.push_back('{v: 4'hF, d: m_data});
                m_ptr = 0;
            end
        end
    endtask

    // One clock; any strobe seen is popped from the scoreboard and compared.
    task automatic tick();
        exp_t e;
        @(posedge clk_32f);
        #1;
        if (valid_out !== 4'h0) begin
            n_strobes++;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got valid=%h data=%h, expected no strobe", valid_out, data_out);
            end else begin
                e = sb_q.pop_front();
                if ({valid_out, data_out} !== e) begin
                    n_fail++;
                    $display("FAIL strobe: got valid=%h data=%h, expected valid=%h data=%h",
                             valid_out, data_out, e.v, e.d);
                end
            end
        end
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        model_byte(b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_lock();
        for (int k = 0; k < 4; k++) send_byte(COM);
        m_locked = 1'b1;
        send_byte(COM);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        serial_in = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_32f);
        #1;
        n_checks += 4;
        if (valid_out !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %h, expected 0", valid_out); end
        if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, expected 0", data_out); end
        if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b, expected 0", active); end
        if (idle_out !== 1'b1) begin n_fail++; $display("FAIL reset_idle: got %b, expected 1", idle_out); end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int k = 0; k < 3; k++) send_byte(COM);
        send_byte(8'h55);
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL lock_short: active=%b, expected 0", active); end
        for (int k = 0; k < 4; k++) send_byte(COM);
        n_checks++;
        if (active !== 1'b0) begin n_fail++; $display("FAIL lock_early: active=%b, expected 0", active); end
        m_locked = 1'b1;
        send_byte(COM);
        n_checks += 2;
        if (active !== 1'b1) begin n_fail++; $display("FAIL lock_active: active=%b, expected 1", active); end
        if (idle_out !== 1'b1) begin n_fail++; $display("FAIL lock_idle: idle=%b, expected 1", idle_out); end
    endtask

    task automatic test_group();
        logic [7:0] c;
        c = COM;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        model_byte(c);
        for (int i = 7; i >= 0; i--) begin
            send_bit(c[i]);
            if (i == 7) begin
                n_checks++;
                if (valid_out !== 4'h0) begin n_fail++; $display("FAIL group_latency_early: valid=%h, expected 0", valid_out); end
            end else if (i == 6) begin
                n_checks++;
                if (valid_out !== 4'hF || data_out !== 32'h44332211) begin
                    n_fail++;
                    $display("FAIL group_latency: valid=%h data=%h, expected F 44332211", valid_out, data_out);
                end
            end
        end
        n_checks++;
        if (valid_out !== 4'h0 || data_out !== 32'h44332211) begin
            n_fail++;
            $display("FAIL group_hold: valid=%h data=%h, expected 0 44332211", valid_out, data_out);
        end
    endtask

    task automatic test_flush();
        send_byte(8'hAA); send_byte(8'hBB);
        n_checks++;
        if (idle_out !== 1'b0) begin n_fail++; $display("FAIL flush_busy: idle=%b, expected 0", idle_out); end
        send_byte(COM); send_byte(COM);
        n_checks += 2;
        if (data_out !== 32'h4433BBAA) begin n_fail++; $display("FAIL flush_data: got %h, expected 4433BBAA", data_out); end
        if (idle_out !== 1'b1) begin n_fail++; $display("FAIL flush_idle: idle=%b, expected 1", idle_out); end
    endtask

    task automatic test_interleave();
        send_byte(8'h01); send_byte(COM);
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(COM); send_byte(COM);
        n_checks += 2;
        if (data_out !== 32'h44040302) begin n_fail++; $display("FAIL interleave_data: got %h, expected 44040302", data_out); end
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL interleave_drain: %0d pending, expected 0", sb_q.size()); end
    endtask

    task automatic test_los();
        int s0;
        s0 = n_strobes;
        for (int k = 0; k < 33; k++) send_byte({4'h0, 4'(k % 15 + 1)});
`ifdef PHY_RX_LOS_EN
        send_bit(1'b0); send_bit(1'b0);
        n_checks += 2;
        if (active !== 1'b0) begin n_fail++; $display("FAIL los_active: active=%b, expected 0", active); end
        if (n_strobes - s0 != 7) begin n_fail++; $display("FAIL los_strobes: got %0d, expected 7", n_strobes - s0); end
`else
        send_byte(COM); send_byte(COM);
        n_checks += 2;
        if (active !== 1'b1) begin n_fail++; $display("FAIL nolos_active: active=%b, expected 1", active); end
        if (n_strobes - s0 != 9) begin n_fail++; $display("FAIL nolos_strobes: got %0d, expected 9", n_strobes - s0); end
`endif
    endtask

    task automatic test_reset_mid();
        do_lock();
        send_byte(8'hAA);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks += 3;
        if (valid_out !== 4'h0) begin n_fail++; $display("FAIL rstmid_valid: got %h, expected 0", valid_out); end
        if (active !== 1'b0) begin n_fail++; $display("FAIL rstmid_active: got %b, expected 0", active); end
        if (idle_out !== 1'b1) begin n_fail++; $display("FAIL rstmid_idle: got %b, expected 1", idle_out); end
        model_reset();
        tick();
        n_checks++;
        if (data_out !== 32'h0 || active !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_edge: data=%h active=%b, expected 0 0", data_out, active);
        end
        rst = 1'b0;
        do_lock();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(COM); send_byte(COM);
        n_checks++;
        if (data_out !== 32'h44332211) begin n_fail++; $display("FAIL rstmid_regroup: got %h, expected 44332211", data_out); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_group();
        test_flush();
        test_interleave();
        test_los();
        test_reset_mid();
        n_checks++;
        if (sb_q.size() != 0) begin n_fail++; $display("FAIL final_drain: %0d strobes missing, expected 0", sb_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

endmodule
